// File: rtl/mod_sub_pipe.sv
// Three-stage pipelined modular subtractor: res = (a - b) mod q.
// Borrow chain split at SPLIT bits; final +q correction registered; valid/ready on both ends.
module mod_sub_pipe #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned SPLIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] q,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             wrapped
);

    localparam int unsigned HI_W  = WIDTH - SPLIT;
    localparam int unsigned HI_W1 = HI_W + 1;

    logic             en_c;
    logic             v1;
    logic             v2;
    logic             v3;

    logic [SPLIT-1:0] d_lo1;
    logic             bw1;
    logic [HI_W-1:0]  a_hi1;
    logic [HI_W-1:0]  b_hi1;
    logic [WIDTH-1:0] q1;

    logic [WIDTH-1:0] d2;
    logic             neg2;
    logic [WIDTH-1:0] q2;

    logic [SPLIT:0]   lo_diff_c;
    logic [HI_W:0]    hi_diff_c;
    logic [WIDTH-1:0] corr_c;

    // Whole pipe advances together unless the output slot is full and not taken.
    assign en_c      = !v3 || out_ready;
    assign in_ready  = en_c;
    assign out_valid = v3;

    // Zero-extended differences: the extra MSB is the segment borrow.
    assign lo_diff_c = {1'b0, a[SPLIT-1:0]} - {1'b0, b[SPLIT-1:0]};
    assign hi_diff_c = {1'b0, a_hi1} - {1'b0, b_hi1} - HI_W1'(bw1);
    assign corr_c    = d2 + q2;

    // Stage 1: low half of the borrow chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            d_lo1 <= '0;
            bw1   <= 1'b0;
            a_hi1 <= '0;
            b_hi1 <= '0;
            q1    <= '0;
        end else if (en_c) begin
            v1    <= in_valid;
            d_lo1 <= lo_diff_c[SPLIT-1:0];
            bw1   <= lo_diff_c[SPLIT];
            a_hi1 <= a[WIDTH-1:SPLIT];
            b_hi1 <= b[WIDTH-1:SPLIT];
            q1    <= q;
        end
    end

    // Stage 2: high half with incoming borrow; final borrow marks a < b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            d2   <= '0;
            neg2 <= 1'b0;
            q2   <= '0;
        end else if (en_c) begin
            v2   <= v1;
            d2   <= {hi_diff_c[HI_W-1:0], d_lo1};
            neg2 <= hi_diff_c[HI_W];
            q2   <= q1;
        end
    end

    // Stage 3: conditional +q correction, wrapping modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3      <= 1'b0;
            res     <= '0;
            wrapped <= 1'b0;
        end else if (en_c) begin
            v3      <= v2;
            res     <= neg2 ? corr_c : d2;
            wrapped <= neg2;
        end
    end

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed-vector and scoreboard bench for mod_sub_pipe.
module tb_mod_sub_pipe;

    localparam int unsigned W = 128;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] q;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         wrapped;

    mod_sub_pipe #(.WIDTH(128), .SPLIT(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         wr;
    } vec_t;

    vec_t         vt[12];
    int           total = 0;
    int           bad   = 0;
    logic [W:0]   exp_q[$];
    logic         was_stalled = 1'b0;
    logic [W-1:0] held_res;
    logic         held_wr;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference: wrap when a < b, adding q in 128-bit wrapping arithmetic.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic [W-1:0] rq);
        if (ra < rb) return {1'b1, ra + (rq - rb)};
        return {1'b0, ra - rb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of handshake with scoreboard and stall-stability checks.
    task automatic cycle(input logic iv, input logic [W-1:0] qq, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic ordy);
        logic [W:0] e;
        in_valid  = iv;
        q         = qq;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        if (was_stalled) begin
            chk("hold_valid", W'(out_valid), W'(1'b1));
            chk("hold_res", res, held_res);
            chk("hold_wrapped", W'(wrapped), W'(held_wr));
        end
        if (out_valid && !out_ready) chk("stall_in_ready", W'(in_ready), W'(1'b0));
        if (!out_valid) chk("idle_in_ready", W'(in_ready), W'(1'b1));
        if (iv && in_ready) exp_q.push_back(ref_sub(aa, bb, qq));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", W'(out_valid), W'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("stream_res", res, e[W-1:0]);
                chk("stream_wrapped", W'(wrapped), W'(e[W]));
            end
        end
        was_stalled = out_valid && !out_ready;
        held_res    = res;
        held_wr     = wrapped;
        tick();
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int           lat;
        logic [W-1:0] rq;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vt[0]  = '{128'd17, 128'd5, 128'd3, 128'd2, 1'b0};
        vt[1]  = '{128'd17, 128'd3, 128'd5, 128'd15, 1'b1};
        vt[2]  = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000,
                   128'd1, 128'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[3]  = '{128'd17, 128'd9, 128'd9, 128'd0, 1'b0};
        vt[4]  = '{128'd17, 128'd0, 128'd16, 128'd1, 1'b1};
        vt[5]  = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd0,
                   128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b1};
        vt[6]  = '{'1, ~128'd1, 128'd0, ~128'd1, 1'b0};
        vt[7]  = '{'1, 128'd0, ~128'd1, 128'd1, 1'b1};
        vt[8]  = '{128'd1000, 128'd1, 128'd999, 128'd2, 1'b1};
        vt[9]  = '{128'h10_0000_0000_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000,
                   128'h1_0000_0000_0000_0001, 128'hF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1};
        vt[10] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1_0000_0000_0000_0005,
                   128'hFFFF_FFFF_FFFF_FFFF, 128'd6, 1'b0};
        vt[11] = '{128'd17, 128'd20, 128'd3, 128'd17, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        q         = '0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_res", res, '0);
        chk("rst_wrapped", W'(wrapped), W'(1'b0));
        chk("rst_in_ready", W'(in_ready), W'(1'b1));
        rst_n = 1'b1;
        tick();

        // Directed vectors, one at a time, with latency check.
        for (int i = 0; i < 12; i++) begin
            q        = vt[i].q;
            a        = vt[i].a;
            b        = vt[i].b;
            in_valid = 1'b1;
            #1;
            chk("vec_in_ready", W'(in_ready), W'(1'b1));
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("vec_latency", W'(lat), W'(3));
            chk("vec_res", res, vt[i].res);
            chk("vec_wrapped", W'(wrapped), W'(vt[i].wr));
            tick();
        end

        // Back-to-back stream, then 5 cycles of backpressure, then drain.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 128'd17, W'(i % 17), W'((3 * i + 5) % 17), 1'b1);
        for (int i = 6; i < 11; i++)
            cycle(1'b1, 128'd17, W'(i % 17), W'((3 * i + 5) % 17), 1'b0);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, '0, '0, '0, 1'b1);
        chk("bp_drained", W'(exp_q.size()), W'(0));

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 128'd17, W'(i + 1), W'(10), 1'b0);
        chk("pre_rst_valid", W'(out_valid), W'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(1'b0));
        chk("mid_rst_res", res, '0);
        exp_q.delete();
        was_stalled = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            cycle(1'b0, '0, '0, '0, 1'b1);

        // Random operands, moduli and handshake.
        for (int i = 0; i < 14000; i++) begin
            case ($urandom_range(0, 2))
                0:       rq = W'($urandom_range(1, 1000));
                1:       rq = {64'd0, $urandom, $urandom};
                default: rq = rnd128();
            endcase
            if (rq == '0) rq = 128'd1;
            ra = rnd128() % rq;
            rb = rnd128() % rq;
            cycle($urandom_range(0, 3) != 0, rq, ra, rb, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10; i++)
            cycle(1'b0, '0, '0, '0, 1'b1);
        chk("rand_drained", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
